// File: rtl/run_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | run_link_pkg : shared types/constants for the run-of-four serial link       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package run_link_pkg;

  localparam int unsigned RUN_LEN_DFLT = 4;
  localparam int unsigned DATA_W_DFLT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    GUARD = 2'd2,
    MARK  = 2'd3
  } tx_state_e;

  // Width of a counter that must hold values 0..run_len inclusive.
  function automatic int unsigned cnt_width(input int unsigned run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | run_tracker : last emitted bit, saturating run count and stuff-needed test  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module run_tracker
  import run_link_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DFLT,
  parameter int unsigned CNT_W   = cnt_width(RUN_LEN)
) (
  input  logic clk,
  input  logic aclr,
  input  logic bit_in,
  input  logic cand,
  output logic last,
  output logic stuff_needed
);

  logic             last_d, last_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    last_d = bit_in;
    cnt_d  = CNT_W'(1);
    if (bit_in == last_q) begin
      cnt_d = (cnt_q == CNT_W'(RUN_LEN)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last         = last_q;
  assign stuff_needed = (cnt_q == CNT_W'(RUN_LEN - 1)) && (cand == last_q);

endmodule
`default_nettype wire

// File: rtl/run_stuff_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | run_stuff_tx : bit-stuffing serial transmitter with RUN_LEN framing markers |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module run_stuff_tx
  import run_link_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned RUN_LEN = RUN_LEN_DFLT
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              valid,
  input  logic              mark,
  input  logic              mark_val,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              w,
  output logic              stuffed,
  output logic              done
);

  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned MCNT_W = cnt_width(RUN_LEN);

  tx_state_e          state_d, state_q;
  logic [DATA_W-1:0]  shift_d, shift_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [MCNT_W-1:0]  mcnt_d, mcnt_q;
  logic               mval_d, mval_q;
  logic               w_d, w_q;
  logic               stuffed_d, stuffed_q;
  logic               done_d, done_q;

  logic               last;
  logic               stuff_needed;
  logic               emit_data;
  logic [DATA_W-1:0]  word_src;
  logic [IDX_W-1:0]   idx_src;

  // On the accept edge the word comes straight from the input port.
  assign word_src = (state_q == IDLE) ? data : shift_q;
  assign idx_src  = (state_q == IDLE) ? '0 : idx_q;

  run_tracker #(
    .RUN_LEN (RUN_LEN)
  ) u_tracker (
    .clk          (clk),
    .aclr         (aclr),
    .bit_in       (w_d),
    .cand         (word_src[0]),
    .last         (last),
    .stuff_needed (stuff_needed)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    mcnt_d    = mcnt_q;
    mval_d    = mval_q;
    w_d       = ~last;
    stuffed_d = 1'b0;
    done_d    = 1'b0;
    emit_data = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (mark) begin
            mval_d = mark_val;
            if (last == mark_val) begin
              w_d     = ~mark_val;
              state_d = GUARD;
            end else begin
              w_d     = mark_val;
              mcnt_d  = MCNT_W'(1);
              state_d = MARK;
            end
          end else begin
            emit_data = 1'b1;
          end
        end
      end
      DATA:  emit_data = 1'b1;
      GUARD: begin
        w_d     = mval_q;
        mcnt_d  = MCNT_W'(1);
        state_d = MARK;
      end
      MARK: begin
        w_d    = mval_q;
        mcnt_d = mcnt_q + 1'b1;
        if (mcnt_q == MCNT_W'(RUN_LEN - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared data-bit path for the accept edge and the DATA state.
    if (emit_data) begin
      if (stuff_needed) begin
        w_d       = ~last;
        stuffed_d = 1'b1;
        shift_d   = word_src;
        idx_d     = idx_src;
        state_d   = DATA;
      end else begin
        w_d     = word_src[0];
        shift_d = word_src >> 1;
        idx_d   = idx_src + 1'b1;
        if (idx_src == IDX_W'(DATA_W - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      mcnt_q    <= '0;
      mval_q    <= 1'b0;
      w_q       <= 1'b0;
      stuffed_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      mcnt_q    <= mcnt_d;
      mval_q    <= mval_d;
      w_q       <= w_d;
      stuffed_q <= stuffed_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign w       = w_q;
  assign stuffed = stuffed_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_run_stuff_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_run_stuff_tx : directed + random bench with a queue-based line model     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_run_stuff_tx;

  localparam int DW = 8;
  localparam int RL = 4;

  logic          clk;
  logic          aclr;
  logic          valid;
  logic          mark;
  logic          mark_val;
  logic [DW-1:0] data;
  logic          ready;
  logic          w;
  logic          stuffed;
  logic          done;

  run_stuff_tx #(
    .DATA_W  (DW),
    .RUN_LEN (RL)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .valid    (valid),
    .mark     (mark),
    .mark_val (mark_val),
    .data     (data),
    .ready    (ready),
    .w        (w),
    .stuffed  (stuffed),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: pending payload bits (stuffable) and pending raw marker bits.
  bit pay_q[$];
  bit raw_q[$];
  bit m_last;
  int m_run;
  bit accepted;
  // Run-length detector watching the DUT's actual line.
  bit d_last;
  int d_run;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    pay_q.delete();
    raw_q.delete();
    m_last = 1'b0;
    m_run  = 0;
    d_last = 1'b0;
    d_run  = 0;
  endtask

  task automatic tick();
    bit ew, es, ed, ez;
    es = 1'b0; ed = 1'b0; ez = 1'b0; accepted = 1'b0;
    if (pay_q.size() == 0 && raw_q.size() == 0 && valid) begin
      accepted = 1'b1;
      if (mark) begin
        if (m_last == mark_val) raw_q.push_back(!mark_val);
        repeat (RL) raw_q.push_back(mark_val);
      end else begin
        for (int i = 0; i < DW; i++) pay_q.push_back(data[i]);
      end
    end
    if (raw_q.size() != 0) begin
      ew = raw_q.pop_front();
      ed = (raw_q.size() == 0);
      ez = ed;
    end else if (pay_q.size() != 0) begin
      if (m_run == RL - 1 && pay_q[0] == m_last) begin
        ew = !m_last;
        es = 1'b1;
      end else begin
        ew = pay_q.pop_front();
        ed = (pay_q.size() == 0);
      end
    end else begin
      ew = !m_last;
    end
    m_run  = (ew == m_last) ? m_run + 1 : 1;
    m_last = ew;

    @(posedge clk);
    #1;
    d_run  = (w === d_last) ? d_run + 1 : 1;
    d_last = w;
    check("w", w, ew);
    check("stuffed", stuffed, es);
    check("done", done, ed);
    check("ready", ready, (pay_q.size() == 0 && raw_q.size() == 0));
    check("z", (d_run == RL), ez);
  endtask

  task automatic send(input bit mk, input bit mv, input logic [DW-1:0] d);
    int n;
    valid = 1'b1; mark = mk; mark_val = mv; data = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 40);
    if (!accepted) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed=none expected=accept");
    end
    valid = 1'b0; mark = 1'(($urandom)); mark_val = 1'($urandom); data = DW'($urandom);
    n = 0;
    while ((pay_q.size() != 0 || raw_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_last(input bit b);
    for (int n = 0; n < 4 && m_last != b; n++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w"}, w, 1'b0);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_stuffed"}, stuffed, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    aclr = 1'b0; valid = 1'b0; mark = 1'b0; mark_val = 1'b0; data = '0;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    #2 aclr = 1'b1;

    repeat (4) tick();              // idle toggling 1,0,1,0
    send(1'b0, 1'b0, 8'hA5);        // last=0 at accept
    send(1'b0, 1'b0, 8'h00);        // last=1, two stuff bits
    wait_last(1'b1);
    send(1'b0, 1'b0, 8'hE0);        // back-to-back, stuff across boundary
    send(1'b0, 1'b0, 8'h01);
    repeat (2) tick();
    wait_last(1'b1);
    send(1'b1, 1'b1, '0);           // guarded marker
    wait_last(1'b1);
    send(1'b1, 1'b0, '0);           // unguarded marker
    send(1'b0, 1'b0, 8'hFF);
    send(1'b1, 1'b1, '0);
    send(1'b0, 1'b0, 8'h0F);
    repeat (2) tick();

    // Asynchronous reset in the middle of a word
    valid = 1'b1; mark = 1'b0; data = 8'hFF;
    tick();
    valid = 1'b0;
    repeat (2) tick();
    #2 aclr = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    #2 aclr = 1'b1;
    model_reset();
    repeat (4) tick();

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      send(($urandom_range(0, 4) == 0), 1'($urandom), DW'($urandom));
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
